// File: rtl/bus_hold_tx.sv
// Source-domain sender that keeps each driven bus word stable for at least HOLD_CYCLES clocks.
// Optional BUS_HOLD_TX_COALESCE_EN: accept during HOLD and forward the latest value back-to-back.
module bus_hold_tx #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             upd_toggle,
    output logic             busy
);
    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 4 || HOLD_CYCLES > 256) begin : g_bad_hold
        $error("bus_hold_tx: HOLD_CYCLES must be in 4..256");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            hs;

    // Handshake: a word transfers on any cycle where in_valid && in_ready.
    assign hs = in_valid && in_ready;

`ifdef BUS_HOLD_TX_COALESCE_EN
    logic [WIDTH-1:0] pend;
    logic             pend_valid;
    logic [WIDTH-1:0] cand;
    logic             cand_valid;

    assign in_ready = 1'b1;

    // A handshake on the final hold cycle beats whatever is already pending.
    always_comb begin
        cand       = pend;
        cand_valid = pend_valid;
        if (hs) begin
            cand       = data_in;
            cand_valid = 1'b1;
        end
    end
`else
    assign in_ready = (state == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            data_out   <= '0;
            upd_toggle <= 1'b0;
            busy       <= 1'b0;
`ifdef BUS_HOLD_TX_COALESCE_EN
            pend       <= '0;
            pend_valid <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hs && (data_in != data_out)) begin
                        data_out   <= data_in;
                        upd_toggle <= ~upd_toggle;
                        busy       <= 1'b1;
                        cnt        <= RELOAD;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
`ifdef BUS_HOLD_TX_COALESCE_EN
                        pend_valid <= 1'b0;
                        if (cand_valid && (cand != data_out)) begin
                            data_out   <= cand;
                            upd_toggle <= ~upd_toggle;
                            cnt        <= RELOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
`ifdef BUS_HOLD_TX_COALESCE_EN
                        if (hs) begin
                            pend       <= data_in;
                            pend_valid <= 1'b1;
                        end
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_hold_tx.sv
// Bench for bus_hold_tx: cycle model of the hold rules checked every cycle, plus pinned literals.
// Inputs change on the falling edge; outputs and model are compared on the falling edge.
module tb_bus_hold_tx;
    localparam int W = 4;
    localparam int H = 8;
`ifdef BUS_HOLD_TX_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] data_out;
    logic         upd_toggle;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    bus_hold_tx #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .upd_toggle(upd_toggle), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: m_left = hold cycles still owed after the last change (0 means idle).
    logic [W-1:0] m_data;
    logic         m_tog;
    int           m_left;
    logic [W-1:0] pend_q[$];
    bit           m_ok = 1'b0;

    task automatic model_change(input logic [W-1:0] v);
        m_data = v;
        m_tog  = ~m_tog;
        m_left = H;
    endtask

    always @(posedge clk) begin : model
        bit           hs;
        bit           have;
        logic [W-1:0] c;
        if (rst) begin
            m_data = '0; m_tog = 1'b0; m_left = 0; pend_q.delete(); m_ok = 1'b1;
        end else if (m_ok) begin
            hs = in_valid && (COAL || m_left == 0);
            if (m_left == 0) begin
                if (hs && data_in != m_data) model_change(data_in);
            end else if (m_left == 1) begin
                have = 1'b0;
                c    = '0;
                if (COAL && hs) begin
                    have = 1'b1; c = data_in;
                end else if (COAL && pend_q.size() > 0) begin
                    have = 1'b1; c = pend_q[$];
                end
                pend_q.delete();
                if (have && c != m_data) model_change(c);
                else m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (COAL && hs) pend_q.push_back(data_in);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_busy, exp_rdy;
        if (m_ok) begin
            exp_busy = (m_left > 0);
            exp_rdy  = COAL ? 1'b1 : (m_left == 0);
            n_vec++;
            if (data_out !== m_data || upd_toggle !== m_tog || busy !== exp_busy || in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL cycle_model t=%0t: got data_out=%h tog=%b busy=%b rdy=%b, want %h %b %b %b",
                         $time, data_out, upd_toggle, busy, in_ready, m_data, m_tog, exp_busy, exp_rdy);
            end
        end
    end

    task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [W-1:0] d);
        rst = r; in_valid = v; data_in = d;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [W-1:0] vec_d [16] = '{4'h7, 4'h7, 4'h0, 4'hF, 4'hF, 4'h8, 4'h1, 4'h1,
                                 4'hE, 4'h2, 4'h2, 4'h9, 4'h9, 4'h4, 4'hC, 4'h6};

    initial begin
        wait_n(2);
        lit("reset_data", data_out, 4'h0);
        lit("reset_tog", {3'b0, upd_toggle}, 4'h0);
        lit("reset_busy", {3'b0, busy}, 4'h0);
        lit("reset_ready", {3'b0, in_ready}, 4'h1);

        // Single accept of A: one-cycle latency, busy/ready for exactly H cycles.
        drive(0, 1, 4'hA);
        wait_n(1);
        drive(0, 0, 4'h0);
        lit("accept_data", data_out, 4'hA);
        lit("accept_tog", {3'b0, upd_toggle}, 4'h1);
        lit("accept_busy", {3'b0, busy}, 4'h1);
        wait_n(7);
        lit("hold_last_busy", {3'b0, busy}, 4'h1);
        wait_n(1);
        lit("hold_end_busy", {3'b0, busy}, 4'h0);
        lit("hold_end_ready", {3'b0, in_ready}, 4'h1);

        // Same value is consumed without any change.
        drive(0, 1, 4'hA);
        wait_n(1);
        drive(0, 0, 4'h0);
        lit("same_data", data_out, 4'hA);
        lit("same_tog", {3'b0, upd_toggle}, 4'h1);
        lit("same_busy", {3'b0, busy}, 4'h0);

        // Accept C, then hold 3 valid from the next cycle onward.
        drive(0, 1, 4'hC);
        wait_n(1);
        drive(0, 1, 4'h3);
        lit("c_data", data_out, 4'hC);
`ifdef BUS_HOLD_TX_COALESCE_EN
        wait_n(7);
        lit("co_pre_data", data_out, 4'hC);
        wait_n(1);
        lit("co_next_data", data_out, 4'h3);
`else
        wait_n(8);
        lit("pre_next_data", data_out, 4'hC);
        wait_n(1);
        lit("next_data_9", data_out, 4'h3);
        lit("next_tog", {3'b0, upd_toggle}, 4'h1);
`endif
        drive(0, 0, 4'h0);
        wait_n(10);

        // Reset part-way through a hold.
        drive(0, 1, 4'hA);
        wait_n(1);
        drive(0, 0, 4'h0);
        wait_n(3);
        lit("pre_rst_data", data_out, 4'hA);
        drive(1, 0, 4'h0);
        wait_n(1);
        drive(0, 0, 4'h0);
        lit("rst_data", data_out, 4'h0);
        lit("rst_busy", {3'b0, busy}, 4'h0);
        lit("rst_ready", {3'b0, in_ready}, 4'h1);
        lit("rst_tog", {3'b0, upd_toggle}, 4'h0);

`ifdef BUS_HOLD_TX_COALESCE_EN
        // Latest pending value wins; 2 is never driven.
        drive(0, 1, 4'h1);
        wait_n(1);
        drive(0, 1, 4'h2);
        lit("co_first", data_out, 4'h1);
        wait_n(1);
        drive(0, 1, 4'h5);
        wait_n(1);
        drive(0, 0, 4'h0);
        wait_n(5);
        lit("co_hold_data", data_out, 4'h1);
        wait_n(1);
        lit("co_coalesced", data_out, 4'h5);
        lit("co_tog", {3'b0, upd_toggle}, 4'h0);
        lit("co_busy", {3'b0, busy}, 4'h1);
        drive(0, 1, 4'h5);
        wait_n(1);
        drive(0, 0, 4'h0);
        wait_n(7);
        lit("co_idle_busy", {3'b0, busy}, 4'h0);
        lit("co_idle_data", data_out, 4'h5);
        lit("co_idle_tog", {3'b0, upd_toggle}, 4'h0);
`endif

        // Mixed valid patterns; the per-cycle model covers these.
        for (int i = 0; i < 48; i++) begin
            drive(0, (i % 3) != 1, vec_d[i % 16]);
            wait_n(1);
        end
        drive(0, 0, 4'h0);
        wait_n(H + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
